// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the command-side master and the register slaves.
package axi_lite_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_RESP
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } r_state_e;

endpackage

// File: rtl/axi_lite_master_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R) with master and slave views.
interface axi_lite_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] m_awaddr;
  logic              m_awvalid;
  logic              m_awready;
  logic [DATA_W-1:0] m_wdata;
  logic [STRB_W-1:0] m_wstrb;
  logic              m_wvalid;
  logic              m_wready;
  logic [1:0]        m_bresp;
  logic              m_bvalid;
  logic              m_bready;
  logic [ADDR_W-1:0] m_araddr;
  logic              m_arvalid;
  logic              m_arready;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rvalid;
  logic              m_rready;

  modport master (
    output m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
    output m_araddr, m_arvalid, m_rready,
    input  m_awready, m_wready, m_bresp, m_bvalid,
    input  m_arready, m_rdata, m_rresp, m_rvalid
  );

  modport slave (
    input  m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
    input  m_araddr, m_arvalid, m_rready,
    output m_awready, m_wready, m_bresp, m_bvalid,
    output m_arready, m_rdata, m_rresp, m_rvalid
  );

endinterface

// File: rtl/axi_lite_master_rd.sv
// Read-side FSM of the AXI4-Lite master: one AR request, one R beat per command.
module axi_lite_master_rd
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_read,
  input  logic [ADDR_W-1:0] read_address,
  output logic              read_done,
  output logic [DATA_W-1:0] read_data,
  output logic [1:0]        read_resp,
  output logic              read_busy,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready
);

  r_state_e          state_q, state_d;
  logic [ADDR_W-1:0] araddr_d;
  logic              arvalid_d, rready_d, done_d;
  logic [DATA_W-1:0] rdata_d;
  logic [1:0]        rresp_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= R_IDLE;
      m_araddr  <= '0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      read_done <= 1'b0;
      read_data <= '0;
      read_resp <= '0;
    end else begin
      state_q   <= state_d;
      m_araddr  <= araddr_d;
      m_arvalid <= arvalid_d;
      m_rready  <= rready_d;
      read_done <= done_d;
      read_data <= rdata_d;
      read_resp <= rresp_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    araddr_d  = m_araddr;
    arvalid_d = m_arvalid;
    rready_d  = m_rready;
    done_d    = 1'b0;
    rdata_d   = read_data;
    rresp_d   = read_resp;
    case (state_q)
      R_IDLE: if (start_read) begin
        araddr_d  = read_address;
        arvalid_d = 1'b1;
        state_d   = R_ADDR;
      end
      R_ADDR: if (m_arvalid && m_arready) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = R_DATA;
      end
      R_DATA: if (m_rvalid && m_rready) begin
        rdata_d  = m_rdata;
        rresp_d  = m_rresp;
        rready_d = 1'b0;
        done_d   = 1'b1;
        state_d  = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end

  assign read_busy = (state_q != R_IDLE);

endmodule

// File: rtl/axi_lite_master.sv
// AXI4-Lite master: turns start_write/start_read commands into AW/W/B and AR/R
// handshakes. Write FSM lives here; the read FSM is a separate sub-module.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W  // 32 or 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_write,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              start_read,
  input  logic [ADDR_W-1:0] read_address,
  output logic              write_done,
  output logic [1:0]        write_resp,
  output logic              write_busy,
  output logic              read_done,
  output logic [DATA_W-1:0] read_data,
  output logic [1:0]        read_resp,
  output logic              read_busy,
  axi_lite_master_if.master m_axi
);

  localparam int STRB_W = DATA_W / 8;

  w_state_e          state_q, state_d;
  logic [ADDR_W-1:0] awaddr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              awvalid_d, wvalid_d, bready_d;
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic              done_d;
  logic [1:0]        resp_d;
  logic              aw_hs, w_hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= W_IDLE;
      m_axi.m_awaddr  <= '0;
      m_axi.m_wdata   <= '0;
      m_axi.m_awvalid <= 1'b0;
      m_axi.m_wvalid  <= 1'b0;
      m_axi.m_bready  <= 1'b0;
      aw_done_q       <= 1'b0;
      w_done_q        <= 1'b0;
      write_done      <= 1'b0;
      write_resp      <= '0;
    end else begin
      state_q         <= state_d;
      m_axi.m_awaddr  <= awaddr_d;
      m_axi.m_wdata   <= wdata_d;
      m_axi.m_awvalid <= awvalid_d;
      m_axi.m_wvalid  <= wvalid_d;
      m_axi.m_bready  <= bready_d;
      aw_done_q       <= aw_done_d;
      w_done_q        <= w_done_d;
      write_done      <= done_d;
      write_resp      <= resp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    awaddr_d  = m_axi.m_awaddr;
    wdata_d   = m_axi.m_wdata;
    awvalid_d = m_axi.m_awvalid;
    wvalid_d  = m_axi.m_wvalid;
    bready_d  = m_axi.m_bready;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    done_d    = 1'b0;
    resp_d    = write_resp;
    aw_hs     = m_axi.m_awvalid && m_axi.m_awready;
    w_hs      = m_axi.m_wvalid && m_axi.m_wready;
    case (state_q)
      W_IDLE: if (start_write) begin
        awaddr_d  = write_address;
        wdata_d   = write_data;
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = W_ADDR;
      end
      W_ADDR: begin
        // AW and W retire independently; either order or the same edge.
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          bready_d = 1'b1;
          state_d  = W_RESP;
        end
      end
      W_RESP: if (m_axi.m_bvalid && m_axi.m_bready) begin
        resp_d   = m_axi.m_bresp;
        bready_d = 1'b0;
        done_d   = 1'b1;
        state_d  = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
  end

  assign write_busy    = (state_q != W_IDLE);
  assign m_axi.m_wstrb = {STRB_W{1'b1}};

  axi_lite_master_rd #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_rd (
    .clk          (clk),
    .rst          (rst),
    .start_read   (start_read),
    .read_address (read_address),
    .read_done    (read_done),
    .read_data    (read_data),
    .read_resp    (read_resp),
    .read_busy    (read_busy),
    .m_araddr     (m_axi.m_araddr),
    .m_arvalid    (m_axi.m_arvalid),
    .m_arready    (m_axi.m_arready),
    .m_rdata      (m_axi.m_rdata),
    .m_rresp      (m_axi.m_rresp),
    .m_rvalid     (m_axi.m_rvalid),
    .m_rready     (m_axi.m_rready)
  );

endmodule
